req_arbiter: RTL and testbench

Sequential 16-requester arbiter for one shared resource. It uses a 16-to-4 priority encoder to pick a winner, registers a one-hot grant plus a 4-bit grant index, and holds the grant until the owner drops its request or a hold-time limit expires. It sits between requesting agents and the shared datapath; `grant_id` drives the resource's select mux.

---
 rtl/req_arbiter_pkg.sv | 21 ++
 rtl/req_arbiter_prio_enc16.sv | 19 +
 rtl/req_arbiter.sv | 119 +++++++++++
 tb/tb_req_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/req_arbiter_pkg.sv
// Shared widths, state encoding and one-hot helper for the request arbiter.
// Pure declarations: no latency, no flow control.
// Imported by req_arbiter; widths here size every grant/index bus.
package req_arbiter_pkg;

  localparam int NREQ   = 16;
  localparam int IDW    = 4;
  localparam int HOLD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    logic [NREQ-1:0] v;
    v = {{(NREQ-1){1'b0}}, 1'b1} << id;
    return v;
  endfunction

endpackage

// File: rtl/req_arbiter_prio_enc16.sv
// prio_enc16: combinational 16-to-4 priority encoder, highest set index wins.
// Zero latency; no flow control. out is 0 whenever valid is low.
// Pure combinational function of in.
module prio_enc16 (
  input  logic [15:0] in,
  output logic [3:0]  out,
  output logic        valid
);

  always_comb begin
    out = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (in[i]) out = 4'(i);
    end
  end

  assign valid = |in;

endmodule

// File: rtl/req_arbiter.sv
// 16-requester arbiter with hold limit; REQ_ARBITER_RR_EN selects round-robin over fixed priority.
// Latency: request to grant 1 cycle, release to idle 1 cycle, at least one idle cycle between owners.
// No preemption: owner keeps the grant until its request drops or MAX_HOLD revokes it.
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            grant_valid,
  output logic            timeout
);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [NREQ-1:0]   skip_mask, skip_nxt;
  logic [IDW-1:0]    id_nxt;
  logic              timeout_nxt;
  logic              issue;

  logic [NREQ-1:0]   masked, arb_vec, enc_in;
  logic [IDW-1:0]    enc_out, win_id;
  logic              enc_valid;
  logic              owner_req, limit_hit;

  // A requester revoked by timeout steps aside once, unless it is the only one asking.
  assign masked  = req & ~skip_mask;
  assign arb_vec = (|masked) ? masked : req;

`ifdef REQ_ARBITER_RR_EN
  logic [IDW-1:0]    rr_ptr;
  logic [2*NREQ-1:0] rot_dbl;

  // Rotate so bit rr_ptr-1 lands on bit 15; the last owner then sits at bit 0.
  assign rot_dbl = {arb_vec, arb_vec} >> rr_ptr;
  assign enc_in  = rot_dbl[NREQ-1:0];
  assign win_id  = enc_out + rr_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)     rr_ptr <= 4'd15;
    else if (issue) rr_ptr <= win_id;
  end
`else
  assign enc_in = arb_vec;
  assign win_id = enc_out;
`endif

  prio_enc16 u_enc (
    .in    (enc_in),
    .out   (enc_out),
    .valid (enc_valid)
  );

  assign owner_req = req[grant_id];
  assign limit_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_comb begin
    state_nxt   = state;
    id_nxt      = grant_id;
    hold_nxt    = hold_cnt;
    skip_nxt    = skip_mask;
    timeout_nxt = 1'b0;
    issue       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && enc_valid) begin
          state_nxt = ST_OWN;
          id_nxt    = win_id;
          hold_nxt  = '0;
          skip_nxt  = '0;
          issue     = 1'b1;
        end
      end
      ST_OWN: begin
        // A request dropping on the limit edge counts as a normal release.
        if (!owner_req) begin
          state_nxt = ST_IDLE;
          id_nxt    = '0;
          hold_nxt  = '0;
        end else if (limit_hit) begin
          state_nxt   = ST_IDLE;
          id_nxt      = '0;
          hold_nxt    = '0;
          skip_nxt    = onehot(grant_id);
          timeout_nxt = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_id  <= '0;
      grant     <= '0;
      hold_cnt  <= '0;
      skip_mask <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_id  <= id_nxt;
      grant     <= (state_nxt == ST_OWN) ? onehot(id_nxt) : '0;
      hold_cnt  <= hold_nxt;
      skip_mask <= skip_nxt;
      timeout   <= timeout_nxt;
    end
  end

  assign grant_valid = (state == ST_OWN);

endmodule

// File: tb/tb_req_arbiter.sv
// Scoreboarded bench for req_arbiter: directed scenarios then random traffic vs. an ownership-level model.
module tb_req_arbiter;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] req = 16'h0;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        timeout;

  typedef struct {
    logic [15:0] g;
    logic [3:0]  id;
    logic        v;
    logic        to;
  } exp_t;

  exp_t expq[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   cyc      = 0;

  // Model state: who owns, how many grant cycles shown, who was last timed out.
  int m_owner = -1;
  int m_held  = 0;
  int m_skip  = -1;
  int m_rr    = 15;

  req_arbiter #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [15:0] v, input int rr);
    int w;
    w = -1;
`ifdef REQ_ARBITER_RR_EN
    for (int k = 1; k <= 16; k++) begin
      if (w < 0 && v[(rr - k + 32) % 16]) w = (rr - k + 32) % 16;
    end
`else
    for (int i = 15; i >= 0; i--) begin
      if (w < 0 && v[i]) w = i;
    end
`endif
    return w;
  endfunction

  // Apply one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic en, input logic [15:0] rq);
    exp_t        e;
    logic [15:0] cand;
    logic        to;
    @(negedge clk);
    rst_n  = r;
    enable = en;
    req    = rq;
    to     = 1'b0;
    if (!r) begin
      m_owner = -1; m_held = 0; m_skip = -1; m_rr = 15;
    end else if (m_owner >= 0) begin
      if (!rq[m_owner]) begin
        m_owner = -1;
      end else if (MH != 0 && m_held == MH) begin
        m_skip  = m_owner;
        m_owner = -1;
        to      = 1'b1;
      end else begin
        m_held++;
      end
    end else if (en && rq != 16'h0) begin
      cand = rq;
      if (m_skip >= 0) cand[m_skip] = 1'b0;
      if (cand == 16'h0) cand = rq;
      m_owner = pick(cand, m_rr);
      m_rr    = m_owner;
      m_held  = 1;
      m_skip  = -1;
    end
    e.v  = (m_owner >= 0);
    e.id = e.v ? 4'(m_owner) : 4'd0;
    e.g  = e.v ? (16'h1 << m_owner) : 16'h0;
    e.to = to;
    expq.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        tot_cnt++;
        if (grant === e.g && grant_id === e.id && grant_valid === e.v && timeout === e.to)
          pass_cnt++;
        else
          $display("FAIL outputs cyc%0d: got g=%h id=%0d v=%b to=%b, expected g=%h id=%0d v=%b to=%b",
                   cyc, grant, grant_id, grant_valid, timeout, e.g, e.id, e.v, e.to);
      end
    end
  end

  initial begin : stim
    logic [15:0] rq;
    // Reset with all requests high, then release.
    step(0, 1, 16'hFFFF);
    step(0, 1, 16'hFFFF);
    step(1, 1, 16'hFFFF);
    step(1, 1, 16'h0000);
    // Fixed priority 5 over 2, then hand-over to 2.
    step(1, 1, 16'h0024);
    step(1, 1, 16'h0024);
    step(1, 1, 16'h0004);
    step(1, 1, 16'h0004);
    step(1, 1, 16'h0004);
    step(1, 1, 16'h0000);
    // Timeout alternation between 15 and 0, then 0 drops.
    repeat (12) step(1, 1, 16'h8001);
    repeat (6) step(1, 1, 16'h8000);
    step(1, 1, 16'h0000);
    // Lone requester timed out and re-granted.
    repeat (12) step(1, 1, 16'h0008);
    step(1, 1, 16'h0000);
    // Owner drops and re-raises each turn.
    for (int t = 0; t < 5; t++) begin
      step(1, 1, 16'h0111);
      step(1, 1, 16'h0111);
      step(1, 1, 16'h0111 & ~(16'h1 << m_owner));
    end
    step(1, 1, 16'h0000);
    // Enable low mid-ownership keeps the grant; no new grants after release.
    step(1, 1, 16'h0080);
    step(1, 0, 16'h00FF);
    step(1, 0, 16'h0080);
    step(1, 0, 16'h0000);
    repeat (3) step(1, 0, 16'h00FF);
    // Reset during ownership: no timeout pulse.
    step(1, 1, 16'h0080);
    step(1, 1, 16'h0080);
    step(0, 1, 16'h0080);
    step(1, 0, 16'h0000);
    // Random traffic.
    rq = 16'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 7) != 0), rq);
    end
    step(1, 1, 16'h0000);
    repeat (3) @(negedge clk);
    if (expq.size() != 0) begin
      tot_cnt++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", expq.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
